// File: rtl/szamologep_p.sv
// szamologep_p: four-button calculator with synchronised, edge-detected buttons and a chaining entry FSM
module szamologep_p #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] dip_sw,
    input  logic [3:0]        btn,
    output logic [DATA_W-1:0] leds,
    output logic [2:0]        flags,
    output logic [2:0]        state,
    output logic              res_vld
);
    typedef enum logic [2:0] {IDLE = 3'd0, HAVE_A = 3'd1, HAVE_OP = 3'd2, HAVE_B = 3'd3, RESULT = 3'd4} state_t;
    state_t st;
    logic [SYNC_STAGES-1:0][3:0] sync;
    logic [SYNC_STAGES-1:0]      flush;
    logic [3:0]                  prev, arm, ev;
    logic                        one_ev;
    logic [DATA_W-1:0]           a, b, result, alu_r;
    logic [2:0]                  op;
    logic                        alu_c, alu_e;
    logic [DATA_W:0]             sum, diff;
    logic [2*DATA_W-1:0]         prod;
    // a button only arms once it has been seen released after the synchroniser has flushed post-reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync  <= '0;
            prev  <= '0;
            arm   <= '0;
            flush <= '0;
        end else begin
            sync  <= {sync[SYNC_STAGES-2:0], btn};
            prev  <= sync[SYNC_STAGES-1];
            flush <= {flush[SYNC_STAGES-2:0], 1'b1};
            arm   <= arm | ({4{flush[SYNC_STAGES-1]}} & ~sync[SYNC_STAGES-1]);
        end
    end
    assign ev     = sync[SYNC_STAGES-1] & ~prev & arm;
    assign one_ev = (ev != 4'd0) && ((ev & (ev - 4'd1)) == 4'd0);
    assign sum    = {1'b0, a} + {1'b0, b};
    assign diff   = {1'b0, a} - {1'b0, b};
    assign prod   = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
    always_comb begin
        alu_r = '0;
        alu_c = 1'b0;
        alu_e = 1'b0;
        case (op)
            3'd0: begin alu_r = sum[DATA_W-1:0];  alu_c = sum[DATA_W]; end
            3'd1: begin alu_r = diff[DATA_W-1:0]; alu_c = diff[DATA_W]; end
            3'd2: begin alu_r = prod[DATA_W-1:0]; alu_c = |prod[2*DATA_W-1:DATA_W]; end
            3'd3: alu_r = a & b;
            3'd4: alu_r = a | b;
            3'd5: alu_r = a ^ b;
            default: alu_e = 1'b1;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            st      <= IDLE;
            a       <= '0;
            b       <= '0;
            op      <= '0;
            result  <= '0;
            leds    <= '0;
            flags   <= '0;
            res_vld <= 1'b0;
        end else begin
            res_vld <= 1'b0;
            if (one_ev) begin
                if (ev[3]) begin
                    a    <= dip_sw;
                    leds <= dip_sw;
                    st   <= HAVE_A;
                end else if (ev[2] && (st == HAVE_A || st == RESULT)) begin
                    if (st == RESULT) a <= result;
                    op   <= dip_sw[2:0];
                    leds <= {{(DATA_W-3){1'b0}}, dip_sw[2:0]};
                    st   <= HAVE_OP;
                end else if (ev[1] && st == HAVE_OP) begin
                    b    <= dip_sw;
                    leds <= dip_sw;
                    st   <= HAVE_B;
                end else if (ev[0] && st == HAVE_B) begin
                    result  <= alu_r;
                    leds    <= alu_r;
                    flags   <= {alu_e, alu_c, alu_r == '0};
                    res_vld <= 1'b1;
                    st      <= RESULT;
                end
            end
        end
    end
    assign state = st;
endmodule

// File: tb/tb_szamologep_p.sv
// tb_szamologep_p: 8- and 12-bit calculators driven in lockstep against a press-level behavioural model
module tb_szamologep_p;
    localparam int SYNC = 2;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] dip;
    logic [3:0]  btn;
    logic [7:0]  leds8;
    logic [11:0] leds12;
    logic [2:0]  flags8, flags12, st8, st12;
    logic        vld8, vld12;
    int vectors = 0;
    int errors  = 0;
    bit chk_en  = 0;
    int wid[2] = '{8, 12};
    int m_st[2], m_a[2], m_b[2], m_op[2], m_res[2], m_leds[2], m_flags[2], m_vld[2];

    always #5 clk = ~clk;

    szamologep_p #(.DATA_W(8), .SYNC_STAGES(SYNC)) u8 (
        .clk(clk), .reset(reset), .dip_sw(dip[7:0]), .btn(btn),
        .leds(leds8), .flags(flags8), .state(st8), .res_vld(vld8));
    szamologep_p #(.DATA_W(12), .SYNC_STAGES(SYNC)) u12 (
        .clk(clk), .reset(reset), .dip_sw(dip[11:0]), .btn(btn),
        .leds(leds12), .flags(flags12), .state(st12), .res_vld(vld12));

    task automatic chk(input string n, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_st[k] = 0; m_a[k] = 0; m_b[k] = 0; m_op[k] = 0;
            m_res[k] = 0; m_leds[k] = 0; m_flags[k] = 0; m_vld[k] = 0;
        end
    endfunction

    // one detected button event, as the user sees it
    function automatic void apply(input logic [3:0] mask, input int d);
        if ($countones(mask) != 1) return;
        for (int k = 0; k < 2; k++) begin
            int m, dv, r, c, e, p;
            m  = (1 << wid[k]) - 1;
            dv = d & m;
            if (mask == 4'b1000) begin
                m_a[k] = dv; m_leds[k] = dv; m_st[k] = 1;
            end else if (mask == 4'b0100 && (m_st[k] == 1 || m_st[k] == 4)) begin
                if (m_st[k] == 4) m_a[k] = m_res[k];
                m_op[k] = d & 7; m_leds[k] = d & 7; m_st[k] = 2;
            end else if (mask == 4'b0010 && m_st[k] == 2) begin
                m_b[k] = dv; m_leds[k] = dv; m_st[k] = 3;
            end else if (mask == 4'b0001 && m_st[k] == 3) begin
                r = 0; c = 0; e = 0;
                case (m_op[k])
                    0: begin p = m_a[k] + m_b[k]; r = p & m; c = int'(p > m); end
                    1: begin r = (m_a[k] - m_b[k]) & m; c = int'(m_a[k] < m_b[k]); end
                    2: begin p = m_a[k] * m_b[k]; r = p & m; c = int'((p >> wid[k]) != 0); end
                    3: r = m_a[k] & m_b[k];
                    4: r = m_a[k] | m_b[k];
                    5: r = m_a[k] ^ m_b[k];
                    default: e = 1;
                endcase
                m_res[k] = r; m_leds[k] = r; m_st[k] = 4; m_vld[k] = 1;
                m_flags[k] = e * 4 + c * 2 + int'(r == 0);
            end
        end
    endfunction

    always @(negedge clk) if (chk_en) begin
        chk("leds8", leds8, m_leds[0]);
        chk("flags8", flags8, m_flags[0]);
        chk("state8", st8, m_st[0]);
        chk("res_vld8", vld8, m_vld[0]);
        chk("leds12", leds12, m_leds[1]);
        chk("flags12", flags12, m_flags[1]);
        chk("state12", st12, m_st[1]);
        chk("res_vld12", vld12, m_vld[1]);
    end

    // outputs must change exactly SYNC+1 edges after the press; dip_sw is scrambled after release
    task automatic press(input logic [3:0] mask, input int d);
        @(negedge clk); dip = d[15:0]; btn = mask;
        repeat (SYNC + 1) @(posedge clk);
        apply(mask, d);
        @(posedge clk);
        m_vld = '{0, 0};
        repeat ($urandom_range(0, 2)) @(posedge clk);
        @(negedge clk); btn = 4'd0; dip = 16'($urandom);
        repeat (SYNC + 2) @(posedge clk);
    endtask

    task automatic do_reset(input logic [3:0] held);
        @(negedge clk); reset = 1'b0; btn = held;
        @(posedge clk);
        model_reset();
        @(posedge clk);
        @(negedge clk); reset = 1'b1;
        repeat (SYNC + 4) @(posedge clk);
        @(negedge clk); btn = 4'd0;
        repeat (SYNC + 2) @(posedge clk);
    endtask

    initial begin
        reset = 1'b0; btn = 4'd0; dip = 16'd0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b1; chk_en = 1;
        repeat (SYNC + 2) @(posedge clk);
        @(negedge clk);
        chk("rst_state", st8, 0); chk("rst_leds", leds8, 0); chk("rst_flags", flags8, 0);

        press(4'b1000, 15); press(4'b0100, 1); press(4'b0010, 3); press(4'b0001, 0);
        @(negedge clk);
        chk("sub_leds8", leds8, 12); chk("sub_flags8", flags8, 0); chk("sub_state8", st8, 4);
        chk("sub_leds12", leds12, 12); chk("sub_flags12", flags12, 0);

        press(4'b0100, 0); press(4'b0010, 8); press(4'b0001, 0);
        @(negedge clk);
        chk("chain_leds8", leds8, 20); chk("chain_leds12", leds12, 20);

        press(4'b1000, 200); press(4'b0100, 0); press(4'b0010, 100); press(4'b0001, 0);
        @(negedge clk);
        chk("add_leds8", leds8, 44); chk("add_flags8", flags8, 3'b010);
        chk("add_leds12", leds12, 300); chk("add_flags12", flags12, 3'b000);

        press(4'b1000, 16); press(4'b0100, 2); press(4'b0010, 16); press(4'b0001, 0);
        @(negedge clk);
        chk("mul_leds8", leds8, 0); chk("mul_flags8", flags8, 3'b011);
        chk("mul_leds12", leds12, 256); chk("mul_flags12", flags12, 3'b000);

        do_reset(4'd0);
        press(4'b0010, 5);
        @(negedge clk);
        chk("idle_b_state", st8, 0); chk("idle_b_leds", leds8, 0);
        press(4'b1000, 7); press(4'b0001, 0);
        @(negedge clk);
        chk("hava_exec_state", st8, 1); chk("hava_exec_leds", leds8, 7);
        press(4'b1010, 9);
        @(negedge clk);
        chk("double_state", st8, 1); chk("double_leds", leds8, 7);

        press(4'b0100, 7); press(4'b0010, 3); press(4'b0001, 0);
        @(negedge clk);
        chk("err_leds8", leds8, 0); chk("err_flags8", flags8, 3'b101);

        press(4'b1000, 1); press(4'b0100, 0); press(4'b0010, 2);
        @(negedge clk);
        chk("haveb_state", st8, 3);
        do_reset(4'b1000);
        @(negedge clk);
        chk("rst_b_state", st8, 0); chk("rst_b_leds", leds8, 0); chk("rst_b_flags", flags8, 0);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 99) < 4) do_reset(4'($urandom));
            else if ($urandom_range(0, 99) < 80) press(4'b0001 << $urandom_range(0, 3), int'($urandom & 16'hffff));
            else press(4'($urandom), int'($urandom & 16'hffff));
        end

        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/szamologep_p.md
SZAMOLOGEP_P -- requirements
Module: szamologep_p

Interface
REQ-001 SHALL have parameter DATA_W, default 8, operand/result width in bits (legal range 4..16).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, number of button synchroniser flops (legal range 2..3).
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port dip_sw  input  DATA_W  operand value, or opcode in dip_sw[2:0].
REQ-006 SHALL have port btn  input  4  btn[3] load A, btn[2] load op, btn[1] load B, btn[0] execute; asynchronous, level.
REQ-007 SHALL have port leds  output  DATA_W  display value.
REQ-008 SHALL have port flags  output  3  {err, carry, zero}.
REQ-009 SHALL have port state  output  3  current FSM state code.
REQ-010 SHALL have port res_vld  output  1  one-cycle pulse when a new result is latched.

Function
REQ-011 SHALL pass each btn bit through SYNC_STAGES flops, then a rising-edge detector; only detected edges (events) act; held buttons act once.
REQ-012 SHALL ignore all events in a cycle where more than one btn event is detected.
REQ-013 SHALL implement FSM states IDLE=0, HAVE_A=1, HAVE_OP=2, HAVE_B=3, RESULT=4.
REQ-014 SHALL transition: IDLE/HAVE_A/HAVE_OP/HAVE_B/RESULT + btn[3] -> HAVE_A, latching A=dip_sw; HAVE_A + btn[2] -> HAVE_OP, latching op=dip_sw[2:0]; HAVE_OP + btn[1] -> HAVE_B, latching B=dip_sw; HAVE_B + btn[0] -> RESULT.
REQ-015 SHALL, in RESULT on btn[2], copy result into A, latch new op, go to HAVE_OP (chained operation).
REQ-016 SHALL ignore any other event/state combination (no state, register or output change).
REQ-017 SHALL compute, for op 0 add A+B, carry=carry-out; op 1 sub A-B mod 2^DATA_W, carry=1 iff A<B; op 2 mul, result=low DATA_W bits, carry=1 iff high DATA_W bits nonzero; op 3 AND; op 4 OR; op 5 XOR, carry=0 for ops 3-5.
REQ-018 SHALL, for op 6 or 7, latch result=0, carry=0, err=1; err=0 for ops 0-5.
REQ-019 SHALL set zero=1 iff latched result==0 (also when err=1).
REQ-020 SHALL latch result and flags on the clock edge that processes the btn[0] event; res_vld high for exactly that following cycle.
REQ-021 SHALL drive leds: IDLE 0; HAVE_A A; HAVE_OP {0..,op}; HAVE_B B; RESULT result.
REQ-022 SHALL hold flags from last execution until next execution or reset; a new btn[3] does not clear flags.
REQ-023 SHALL register all outputs; latency from btn rising (setup met) to leds/state update = SYNC_STAGES+1 rising clk edges.
REQ-024 SHALL never let dip_sw changes after a latch alter stored A, op or B.

Reset
REQ-025 SHALL, when reset=0 at a rising edge, set state=IDLE, A=B=op=result=0, leds=0, flags=000, res_vld=0, synchroniser and edge flops=0.
REQ-026 SHALL let reset override any simultaneous event; a button held through reset release SHALL NOT produce an event until released and pressed again.
REQ-027 SHALL abandon any partial entry on reset (mid-sequence reset returns to IDLE).

Verification
REQ-028 SHALL verify DATA_W=8: A=15, op=1, B=3, execute -> leds=12, flags=000, res_vld one cycle, state=4.
REQ-029 SHALL verify add wrap: A=200, op=0, B=100 -> leds=44, carry=1, zero=0; mul: A=16, op=2, B=16 -> leds=0, carry=1, zero=1.
REQ-030 SHALL verify chaining: 15-3=12, then btn[2] with op=0, btn[1] B=8, execute -> leds=20.
REQ-031 SHALL verify ordering: btn[1] in IDLE and btn[0] in HAVE_A ignored (state/leds unchanged); btn[3]+btn[1] same cycle ignored; held btn[0] gives one res_vld.
REQ-032 SHALL verify op=7 -> leds=0, flags=101; reset asserted in HAVE_B -> state=0, leds=0, flags=000.
REQ-033 SHALL rerun REQ-028 and REQ-029 with DATA_W=12 (200+100=300, carry=0).
